// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer: round-type and
// sequencer-state encodings plus the round-count function.
package aes_pkg;

    typedef enum logic [1:0] {
        RND_NONE  = 2'd0,
        RND_INIT  = 2'd1,
        RND_MID   = 2'd2,
        RND_FINAL = 2'd3
    } rnd_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Nr = K/32 + 6: 10, 12 or 14 rounds for 128, 192 or 256-bit keys.
    function automatic logic [3:0] nr_of(input int unsigned k);
        return 4'(k / 32 + 6);
    endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Loadable 4-bit round counter with synchronous clear, enable and a
// terminal-count flag that also stops further increments.
module aes_round_cnt
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    input  logic [3:0] nr_i,
    output logic [3:0] cnt_o,
    output logic       tc_o
);

    logic [3:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == nr_i);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/aes_round_seq.sv
// AES round sequencer: accepts a key/block pair, primes the key-expansion
// unit, steps the datapath through INIT/MID/FINAL rounds and holds the result.
module aes_round_seq
    import aes_pkg::*;
#(
    parameter int K = 128
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K-1:0]   in_key,
    input  logic [127:0]   in_block,
    output logic           ks_rst,
    output logic           ks_hold,
    output logic [K-1:0]   ks_key,
    output logic [127:0]   dp_block,
    output logic [1:0]     rnd_sel,
    output logic [3:0]     rnd_idx,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam logic [3:0] NR = nr_of(K);

    seq_state_e     state_q, state_d;
    logic [K-1:0]   key_q, key_d;
    logic [127:0]   blk_q, blk_d;
    rnd_sel_e       sel;
    logic           accept;
    logic           cnt_en;
    logic           cnt_tc;

    aes_round_cnt u_cnt (
        .clk        (clk),
        .clr_i      (reset),
        .load_i     (accept),
        .load_val_i (4'd0),
        .en_i       (cnt_en),
        .nr_i       (NR),
        .cnt_o      (rnd_idx),
        .tc_o       (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        blk_d     = blk_q;
        in_ready  = 1'b0;
        ks_hold   = 1'b0;
        out_valid = 1'b0;
        sel       = RND_NONE;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                ks_hold  = 1'b1;
            end
            ST_PRIME: begin
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                if (rnd_idx == 4'd0) begin
                    sel = RND_INIT;
                end else if (cnt_tc) begin
                    sel = RND_FINAL;
                end else begin
                    sel = RND_MID;
                end
                if (cnt_tc) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                ks_hold   = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A new request overrides whatever next state was chosen above.
        accept = in_valid & in_ready & ~reset;
        if (accept) begin
            state_d = ST_PRIME;
            key_d   = in_key;
            blk_d   = in_block;
        end
        ks_rst = reset | accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            blk_q   <= blk_d;
        end
    end

    assign ks_key   = key_q;
    assign dp_block = blk_q;
    assign rnd_sel  = sel;

endmodule

// File: doc/aes_round_seq.md
AES_ROUND_SEQ -- requirements
Module: aes_round_seq

Interface
REQ-001 SHALL have parameter K, default 128, meaning key length in bits; legal values are 128, 192 and 256.
REQ-002 SHALL have port clk, input, 1 bit, system clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit, requester offers a key/block pair.
REQ-005 SHALL have port in_ready, output, 1 bit, sequencer can accept a request.
REQ-006 SHALL have port in_key, input, K bits, cipher key.
REQ-007 SHALL have port in_block, input, 128 bits, plaintext block.
REQ-008 SHALL have port ks_rst, output, 1 bit, synchronous reset to the key-expansion unit.
REQ-009 SHALL have port ks_hold, output, 1 bit, freeze (done) input to the key-expansion unit.
REQ-010 SHALL have port ks_key, output, K bits, registered key driven to the key-expansion unit.
REQ-011 SHALL have port dp_block, output, 128 bits, registered plaintext for the round datapath.
REQ-012 SHALL have port rnd_sel, output, 2 bits, round type: NONE=0, INIT=1, MID=2, FINAL=3.
REQ-013 SHALL have port rnd_idx, output, 4 bits, current round number 0..Nr.
REQ-014 SHALL have port out_valid, output, 1 bit, ciphertext in datapath is complete.
REQ-015 SHALL have port out_ready, input, 1 bit, consumer accepts the result.

Function
REQ-016 SHALL use Nr = K/32 + 6, giving 10, 12 and 14 rounds.
REQ-017 SHALL implement the states IDLE, PRIME, ROUND and DONE.
REQ-018 SHALL assert in_ready in IDLE, and in DONE when out_ready=1; otherwise in_ready SHALL be 0.
REQ-019 SHALL perform acceptance (in_valid & in_ready) as follows:
  - capture in_key into ks_key and in_block into dp_block;
  - assert ks_rst combinationally in that cycle;
  - move to PRIME.
REQ-020 SHALL, in PRIME, hold ks_rst=0 and ks_hold=0 and set rnd_sel=NONE, so the key-expansion unit loads ks_key; the next state is ROUND with rnd_idx=0.
REQ-021 SHALL, in ROUND, present round key rnd_idx from the key-expansion unit that cycle, with:
  - rnd_sel = INIT when rnd_idx=0;
  - rnd_sel = MID when 1 ≤ rnd_idx ≤ Nr-1;
  - rnd_sel = FINAL when rnd_idx=Nr.
REQ-022 SHALL increment rnd_idx by 1 per ROUND cycle; after rnd_idx=Nr the next state is DONE, with no wrap past Nr.
REQ-023 SHALL, in DONE, assert out_valid=1, ks_hold=1 and rnd_sel=NONE, and hold dp_block, ks_key and rnd_idx=Nr stable until out_ready=1.
REQ-024 SHALL, in DONE with out_ready=1 and in_valid=0, move to IDLE; with out_ready=1 and in_valid=1, accept the new request in the same cycle (REQ-019) and move to PRIME.
REQ-025 SHALL assert ks_hold=1 in IDLE and DONE, and ks_hold=0 in PRIME and ROUND.
REQ-026 SHALL give latency from acceptance at cycle t to out_valid=1 at cycle t+Nr+3 (t+13 for K=128), with throughput of one block per Nr+3 cycles under full-rate handshakes.
REQ-027 SHALL ignore in_valid, in_key and in_block outside acceptance cycles; no mid-operation abort is supported.
REQ-028 SHALL keep out_valid=1 until it is consumed once asserted, i.e. it SHALL NOT drop without out_ready.

Reset
REQ-029 SHALL, on reset=1, drive the state to IDLE with rnd_idx=0, ks_key=0 and dp_block=0 at the next edge.
REQ-030 SHALL assert ks_rst=1 whenever reset=1, forwarding reset to the key-expansion unit.
REQ-031 SHALL, after reset, drive outputs as follows: in_ready=1, out_valid=0, rnd_sel=NONE, ks_hold=1.
REQ-032 SHALL, on reset during PRIME, ROUND or DONE, discard the operation with no out_valid.

Structure
REQ-033 SHALL place the rnd_sel enum, the state enum and an Nr(K) constant function in shared package aes_pkg.
REQ-034 SHALL contain one sub-module, aes_round_cnt: a loadable 4-bit counter with clear, enable and terminal-count (== Nr) flag.

Verification
REQ-035 SHALL cover the K=128 FIPS-197 vector:
  - stimulus: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff;
  - response: out_valid at t+13, rnd_sel sequence INIT, MID×9, FINAL, and the datapath yields 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-036 SHALL cover K=192 and K=256 with FIPS-197 keys, requiring out_valid at t+15 and t+17 respectively and ciphertexts dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089.
REQ-037 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, dp_block and ks_hold=1 held stable, and in_ready=0.
REQ-038 SHALL cover back-to-back operation: in_valid held high and out_ready=1 -> second acceptance in the DONE cycle, with a PRIME state and no IDLE gap.
REQ-039 SHALL cover reset mid-operation: reset at rnd_idx=5 -> IDLE next cycle, out_valid never asserted, and a following request produces the correct ciphertext.
